// File: rtl/spi_ahb_pkg.sv
// Shared types and constants for the AHB-Lite front end of the SPI flash
// controller register file.
package spi_ahb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_DATA,
      WR_ISSUE,
      RD_ISSUE,
      RD_WAIT,
      RD_DONE,
      ERR1,
      ERR2
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [31:0] DEF_ADDR_LIMIT = 32'h24;
   localparam logic [31:0] DEF_RO_ADDR    = 32'h24;

endpackage

// File: rtl/ahb_reg_bridge.sv
// AHB-Lite slave that turns word transfers into single-cycle valid/rd0_wr1
// requests to the register file, with wait states, legality checks and a read timeout.
module ahb_reg_bridge
   import spi_ahb_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT = DEF_ADDR_LIMIT,
   parameter logic [31:0] RO_ADDR    = DEF_RO_ADDR,
   parameter int unsigned RD_TIMEOUT = 15
) (
   input  logic        i_clk_ahb,
   input  logic        i_rst_ahb,
   input  logic        i_hsel,
   input  logic [31:0] i_haddr,
   input  logic [1:0]  i_htrans,
   input  logic        i_hwrite,
   input  logic [2:0]  i_hsize,
   input  logic [31:0] i_hwdata,
   input  logic        i_hready,
   output logic        o_hreadyout,
   output logic        o_hresp,
   output logic [31:0] o_hrdata,
   output logic [31:0] o_address,
   output logic        o_rd0_wr1,
   output logic [31:0] o_wr_data,
   output logic        o_valid,
   input  logic [31:0] i_rd_data,
   input  logic        i_rd_valid,
   input  logic        i_ready
);

   localparam int unsigned TO_W = $clog2(RD_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);

   state_t          state;
   logic [TO_W-1:0] to_cnt;
   logic            ro_wr;
   logic            hready_int;
   logic            active;
   logic            accept;
   logic            legal;

   always_comb begin
      hready_int = 1'b0;
      case (state)
         IDLE, RD_DONE, ERR2: hready_int = 1'b1;
         WR_ISSUE:            hready_int = i_ready;
         default:             hready_int = 1'b0;
      endcase
   end

   assign o_hreadyout = hready_int;
   assign o_hresp     = (state == ERR1) || (state == ERR2);

   assign active = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);
   assign accept = i_hsel && i_hready && active && hready_int;
   assign legal  = (i_haddr <= ADDR_LIMIT) && (i_haddr[1:0] == 2'b00) &&
                   (i_hsize == HSIZE_WORD);

   always_ff @(posedge i_clk_ahb) begin
      if (i_rst_ahb) begin
         state     <= IDLE;
         to_cnt    <= '0;
         ro_wr     <= 1'b0;
         o_hrdata  <= '0;
         o_address <= '0;
         o_rd0_wr1 <= 1'b0;
         o_wr_data <= '0;
         o_valid   <= 1'b0;
      end else begin
         case (state)
            WR_DATA: begin
               o_wr_data <= i_hwdata;
               o_valid   <= ~ro_wr;
               o_rd0_wr1 <= 1'b1;
               state     <= WR_ISSUE;
            end
            WR_ISSUE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            RD_ISSUE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  to_cnt  <= '0;
                  state   <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               to_cnt <= to_cnt + 1'b1;
               if (i_rd_valid) begin
                  o_hrdata <= i_rd_data;
                  state    <= RD_DONE;
               end else if (to_cnt == TO_LAST) begin
                  state <= ERR1;
               end
            end
            ERR1:    state <= ERR2;
            default: state <= IDLE;
         endcase

         // A new address phase can only land in a ready state; these
         // assignments come last so they override the completion above.
         if (accept) begin
            if (!legal) begin
               state <= ERR1;
            end else if (i_hwrite) begin
               o_address <= i_haddr;
               ro_wr     <= (i_haddr == RO_ADDR);
               state     <= WR_DATA;
            end else begin
               o_address <= i_haddr;
               o_valid   <= 1'b1;
               o_rd0_wr1 <= 1'b0;
               state     <= RD_ISSUE;
            end
         end
      end
   end

endmodule
